// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART core: one transmitter and one mid-bit sampling receiver on clk.
// Optional macro UART_LOOPBACK_EN adds a loopback input that feeds the internal tx into the receiver.
module uart_core_param #(
  parameter int CLK_FREQ    = 1000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int STOP_CYC = STOP_BITS * BIT_CYC;
  localparam int CW       = $clog2(STOP_CYC + 1);
  localparam int IW       = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t                tx_state_reg, tx_state_next;
  logic [CW-1:0]         tx_cnt_reg, tx_cnt_next;
  logic [IW-1:0]         tx_idx_reg, tx_idx_next;
  logic [DATA_BITS-1:0]  tx_shift_reg, tx_shift_next;
  logic                  tx_par_reg, tx_par_next;
  logic                  tx_reg, tx_bit;
  logic                  tx_done_reg, tx_done_next;

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_idx_next   = tx_idx_reg;
    tx_shift_next = tx_shift_reg;
    tx_par_next   = tx_par_reg;
    tx_bit        = 1'b1;
    tx_done_next  = 1'b0;
    case (tx_state_reg)
      S_IDLE: begin
        if (tx_valid) begin
          tx_shift_next = tx_data;
          tx_par_next   = (PARITY_MODE == 2) ? ^tx_data : ~^tx_data;
          tx_cnt_next   = '0;
          tx_state_next = S_START;
        end
      end
      S_START: begin
        tx_bit = 1'b0;
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_idx_next   = '0;
          tx_state_next = S_DATA;
        end else begin
          tx_cnt_next = tx_cnt_reg + CNT_ONE;
        end
      end
      S_DATA: begin
        tx_bit = tx_shift_reg[0];
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_shift_next = tx_shift_reg >> 1;
          if (tx_idx_reg == IDX_LAST) begin
            tx_state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            tx_idx_next = tx_idx_reg + IDX_ONE;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + CNT_ONE;
        end
      end
      S_PARITY: begin
        tx_bit = tx_par_reg;
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = S_STOP;
        end else begin
          tx_cnt_next = tx_cnt_reg + CNT_ONE;
        end
      end
      S_STOP: begin
        // Stop covers every stop bit in one stretch; done lands with the return to idle.
        if (tx_cnt_reg == STOP_LAST) begin
          tx_cnt_next   = '0;
          tx_done_next  = 1'b1;
          tx_state_next = S_IDLE;
        end else begin
          tx_cnt_next = tx_cnt_reg + CNT_ONE;
        end
      end
      default: tx_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= S_IDLE;
      tx_cnt_reg   <= '0;
      tx_idx_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      tx_done_reg  <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_idx_reg   <= tx_idx_next;
      tx_shift_reg <= tx_shift_next;
      tx_par_reg   <= tx_par_next;
      tx_reg       <= tx_bit;
      tx_done_reg  <= tx_done_next;
    end
  end

  assign tx       = tx_reg;
  assign tx_done  = tx_done_reg;
  assign tx_ready = (tx_state_reg == S_IDLE);

  // ---------------- receiver ----------------
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_reg : rx;
`else
  assign rx_src = rx;
`endif

  logic                  rx_meta_reg, rx_s_reg, rx_prev_reg;
  state_t                rx_state_reg, rx_state_next;
  logic [CW-1:0]         rx_cnt_reg, rx_cnt_next;
  logic [IW-1:0]         rx_idx_reg, rx_idx_next;
  logic [DATA_BITS-1:0]  rx_shift_reg, rx_shift_next;
  logic                  rx_par_reg, rx_par_next;
  logic [DATA_BITS-1:0]  rx_data_reg, rx_data_next;
  logic                  rx_valid_reg, rx_valid_next;
  logic                  rx_perr_reg, rx_perr_next;
  logic                  rx_ferr_reg, rx_ferr_next;
  logic                  rx_exp_par;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_idx_next   = rx_idx_reg;
    rx_shift_next = rx_shift_reg;
    rx_par_next   = rx_par_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    rx_perr_next  = rx_perr_reg;
    rx_ferr_next  = rx_ferr_reg;
    rx_exp_par    = (PARITY_MODE == 2) ? ^rx_shift_reg : ~^rx_shift_reg;
    case (rx_state_reg)
      S_IDLE: begin
        // Only a falling edge arms; a line held low (break) never re-triggers.
        if (rx_prev_reg && !rx_s_reg) begin
          rx_cnt_next   = '0;
          rx_state_next = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next   = '0;
          rx_idx_next   = '0;
          rx_state_next = rx_s_reg ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_s_reg, rx_shift_reg[DATA_BITS-1:1]};
          if (rx_idx_reg == IDX_LAST) begin
            rx_state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            rx_idx_next = rx_idx_reg + IDX_ONE;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_ONE;
        end
      end
      S_PARITY: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_par_next   = rx_s_reg;
          rx_state_next = S_STOP;
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_valid_next = 1'b1;
          rx_data_next  = rx_shift_reg;
          rx_perr_next  = (PARITY_MODE != 0) && (rx_par_reg != rx_exp_par);
          rx_ferr_next  = ~rx_s_reg;
          rx_state_next = S_IDLE;
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_ONE;
        end
      end
      default: rx_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg  <= 1'b1;
      rx_s_reg     <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= S_IDLE;
      rx_cnt_reg   <= '0;
      rx_idx_reg   <= '0;
      rx_shift_reg <= '0;
      rx_par_reg   <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_perr_reg  <= 1'b0;
      rx_ferr_reg  <= 1'b0;
    end else begin
      rx_meta_reg  <= rx_src;
      rx_s_reg     <= rx_meta_reg;
      rx_prev_reg  <= rx_s_reg;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_idx_reg   <= rx_idx_next;
      rx_shift_reg <= rx_shift_next;
      rx_par_reg   <= rx_par_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      rx_perr_reg  <= rx_perr_next;
      rx_ferr_reg  <= rx_ferr_next;
    end
  end

  assign rx_data       = rx_data_reg;
  assign rx_valid      = rx_valid_reg;
  assign rx_parity_err = rx_perr_reg;
  assign rx_frame_err  = rx_ferr_reg;
  assign rx_busy       = (rx_state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: default 8O1 instance plus a 7E2 instance looped tx->rx.
module tb_uart_core_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx, tx_done;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid, rx_parity_err, rx_frame_err, rx_busy;

  logic [6:0] tx_data2;
  logic       tx_valid2, tx_ready2, tx2, tx_done2;
  logic [6:0] rx_data2;
  logic       rx_valid2, rx_perr2, rx_ferr2, rx_busy2;

  int n_cmp = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  int rx_cnt2 = 0;
  int tx_done_cnt = 0;

  uart_core_param u_dut (
    .clk(clk), .rst(rst),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .tx_done(tx_done),
    .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  uart_core_param #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b1),
    .rx(1'b1),
`else
    .rx(tx2),
`endif
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx(tx2), .tx_done(tx_done2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_parity_err(rx_perr2),
    .rx_frame_err(rx_ferr2), .rx_busy(rx_busy2)
  );

  always @(negedge clk) begin
    if (rx_valid) rx_cnt++;
    if (rx_valid2) rx_cnt2++;
    if (tx_done) tx_done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-18s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives one 104-cycle-per-bit 8-bit frame on rx with explicit parity and stop levels.
  task automatic rx_frame(input logic [7:0] d, input logic par, input logic stop_v);
    rx = 1'b0;
    repeat (104) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (104) @(negedge clk);
    end
    rx = par;
    repeat (104) @(negedge clk);
    rx = stop_v;
    repeat (104) @(negedge clk);
  endtask

  // Frame images, bit 0 = start, bits 8:1 = data LSB first, bit 9 = parity, bit 10 = stop.
  logic [10:0] f_a5 = {1'b1, 1'b1, 8'hA5, 1'b0};
  logic [10:0] f_00 = {1'b1, 1'b1, 8'h00, 1'b0};
  logic [10:0] f_ff = {1'b1, 1'b1, 8'hFF, 1'b0};

  int m, done1, done2, rxc, tdc;

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx = 1'b1;
    tx_valid2 = 1'b0; tx_data2 = 7'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_done", tx_done, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_perr", rx_parity_err, 0);
    check("rst_ferr", rx_frame_err, 0);
    check("rst_rx_busy", rx_busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame 8'hA5, odd parity
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("a5_accepted", tx_ready, 0);
    m = 1; done1 = 0;
    while (m <= 1300 && done1 == 0) begin
      if (m >= 54 && m <= 1094 && (m - 54) % 104 == 0) check("a5_bit", tx, f_a5[(m - 54) / 104]);
      if (tx_done) begin
        done1 = m;
        check("a5_ready_at_done", tx_ready, 1);
      end
      m++;
      @(negedge clk);
    end
    check("a5_done_cycle", done1, 1145);
    repeat (5) @(negedge clk);

    // Back-to-back 8'h00 then 8'hFF with tx_valid held
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clk);
    m = 1; done1 = 0; done2 = 0;
    while (m <= 2500 && done2 == 0) begin
      if (m == 5) tx_data = 8'hFF;
      if (m == 1146) begin
        check("b2b_accept2", tx_ready, 0);
        check("b2b_gap", tx, 1);
        tx_valid = 1'b0;
      end
      if (m == 1147) check("b2b_start2", tx, 0);
      if (m >= 54 && m <= 1094 && (m - 54) % 104 == 0) check("b2b_f1_bit", tx, f_00[(m - 54) / 104]);
      if (m >= 1199 && m <= 2239 && (m - 1199) % 104 == 0) check("b2b_f2_bit", tx, f_ff[(m - 1199) / 104]);
      if (tx_done) begin
        if (done1 == 0) done1 = m;
        else done2 = m;
      end
      m++;
      @(negedge clk);
    end
    check("b2b_done1", done1, 1145);
    check("b2b_done2", done2, 2290);
    repeat (20) @(negedge clk);

    // Good RX frame 8'h3C, odd parity bit 1
    rxc = rx_cnt;
    rx_frame(8'h3C, 1'b1, 1'b1);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("rx_good_count", rx_cnt, rxc + 1);
    check("rx_good_data", rx_data, 8'h3C);
    check("rx_good_perr", rx_parity_err, 0);
    check("rx_good_ferr", rx_frame_err, 0);

    // Parity bit flipped
    rxc = rx_cnt;
    rx_frame(8'h3C, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("rx_par_count", rx_cnt, rxc + 1);
    check("rx_par_perr", rx_parity_err, 1);
    check("rx_par_ferr", rx_frame_err, 0);

    // Stop bit low followed by a long break
    rxc = rx_cnt;
    rx_frame(8'h3C, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (1500) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check("rx_brk_count", rx_cnt, rxc + 1);
    check("rx_brk_ferr", rx_frame_err, 1);
    check("rx_brk_perr", rx_parity_err, 0);

    // 40-cycle glitch on idle rx
    rxc = rx_cnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy", rx_busy, 1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_count", rx_cnt, rxc);
    check("glitch_idle", rx_busy, 0);

    // Reset mid-TX (data bit 4) and mid-RX
    tx_data = 8'hA5; tx_valid = 1'b1; rx = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (470) @(negedge clk);
    check("pre_rst_rx_busy", rx_busy, 1);
    check("pre_rst_tx_ready", tx_ready, 0);
    rxc = rx_cnt; tdc = tx_done_cnt;
    rst = 1'b1; rx = 1'b1;
    @(negedge clk);
    check("mrst_tx", tx, 1);
    check("mrst_tx_ready", tx_ready, 1);
    check("mrst_rx_busy", rx_busy, 0);
    check("mrst_rx_valid", rx_valid, 0);
    check("mrst_tx_done", tx_done, 0);
    check("mrst_rx_data", rx_data, 0);
    check("mrst_ferr", rx_frame_err, 0);
    rst = 1'b0;
    repeat (1500) @(negedge clk);
    check("mrst_no_rx_valid", rx_cnt, rxc);
    check("mrst_no_tx_done", tx_done_cnt, tdc);

    // 7E2 instance, tx looped into its own receiver
    rxc = rx_cnt2;
    tx_data2 = 7'h55; tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    m = 1; done1 = 0;
    while (m <= 1300 && done1 == 0) begin
      if (tx_done2) done1 = m;
      m++;
      @(negedge clk);
    end
    check("lb_done_cycle", done1, 1145);
    repeat (20) @(negedge clk);
    check("lb_rx_count", rx_cnt2, rxc + 1);
    check("lb_rx_data", rx_data2, 7'h55);
    check("lb_perr", rx_perr2, 0);
    check("lb_ferr", rx_ferr2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised full-duplex UART core: one transmitter and one oversampling receiver on a single clock domain. Data width, parity mode and stop-bit count are configurable. The receiver reports parity and framing errors. The core sits between the system bus/register block and the serial pins, and replaces the fixed 8-bit, divided-clock UART pair.

Parameters:
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD_RATE, 9600: serial bit rate. BIT_CYC = CLK_FREQ/BAUD_RATE, truncated; must be >= 4.
- DATA_BITS, 8: payload bits per frame; legal range 5..9.
- PARITY_MODE, 1: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock; every flop in the block uses its rising edge.
- rst  in  1  synchronous active-high reset.
- tx_data  in  DATA_BITS  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a word.
- tx  out  1  serial output; idles high.
- tx_done  out  1  one-cycle pulse at the end of each frame.
- rx  in  1  serial input; asynchronous.
- rx_data  out  DATA_BITS  last received word.
- rx_valid  out  1  one-cycle pulse when rx_data and the error flags update.
- rx_parity_err  out  1  parity mismatch in the last frame; held until the next rx_valid.
- rx_frame_err  out  1  first stop bit sampled low; held until the next rx_valid.
- rx_busy  out  1  receiver is inside a frame.

Behaviour:
- Reset values: tx=1, tx_ready=1, tx_done=0, rx_data=0, rx_valid=0, rx_parity_err=0, rx_frame_err=0, rx_busy=0. Both FSMs go to IDLE and all counters clear. Reset takes effect on the same edge even mid-frame; tx returns high on the next cycle.
- Bit timing uses a per-FSM cycle counter running 0..BIT_CYC-1, with no derived clocks. Each serial bit lasts exactly BIT_CYC clk cycles.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY_MODE=0) -> STOP -> IDLE.
- Handshake: a word is accepted on a clk edge where tx_valid && tx_ready. On that edge tx_data is latched and parity is computed, and tx_ready drops. tx goes 0 (start bit) on the next cycle.
- DATA sends LSB first, DATA_BITS bits. Parity bit: odd = ~^data, even = ^data.
- STOP drives 1 for STOP_BITS*BIT_CYC cycles.
- On the last STOP cycle: tx_done=1 for 1 cycle, tx_ready=1 in that same cycle, FSM returns to IDLE.
- If tx_valid is held high, the next word is accepted on the following edge, giving a 1-cycle idle gap between frames. tx_data changes while tx_ready=0 are ignored.
- Frame latency: 1 + (1 + DATA_BITS + P + STOP_BITS) * BIT_CYC cycles from accept to tx_done, where P = 1 when parity is enabled and 0 otherwise.
- RX input: rx passes through a 2-flop synchroniser (rx_s); add 2 cycles of input latency.
- RX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY_MODE=0) -> STOP -> IDLE.
- IDLE: a high-to-low edge on rx_s enters START; rx_busy goes 1.
- START: sample rx_s at BIT_CYC/2 cycles. If it reads 1, the edge was a glitch: return to IDLE, rx_busy=0, no rx_valid.
- DATA and PARITY: each bit is sampled BIT_CYC cycles after the previous sample point (mid-bit). Data shifts in LSB first.
- STOP: sample the first stop bit only. At that sample point: rx_valid=1 for 1 cycle, rx_data updates, rx_parity_err updates (0 when parity is disabled), rx_frame_err = ~stop_sample. The FSM returns to IDLE on the same edge and rx_busy=0.
- A second stop bit is not checked. The receiver re-arms mid-first-stop-bit, so back-to-back frames are accepted.
- Framing error with rx held low: the FSM waits in IDLE until rx_s returns high before arming again (break condition). No repeated rx_valid pulses during a break.
- TX and RX are fully independent; simultaneous tx and rx activity has no interaction.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the receiver's synchroniser input is the internal tx signal instead of rx, and the tx pin still drives normally. loopback is sampled every cycle; changing it mid-frame is legal but that frame's contents are undefined.
- Not defined: the port is absent and the receiver always uses rx.

Test Plan:
- Defaults (BIT_CYC=104, odd parity, 1 stop): send 8'hA5 -> tx: 0,1,0,1,0,0,1,0,1, parity 1, stop 1. tx_done appears 1 + 11*104 = 1145 cycles after accept.
- Hold tx_valid with 8'h00 then 8'hFF -> 2 frames, 1-cycle idle gap, 2 tx_done pulses. Parity bits 1 then 1.
- Drive a 104-cycle-per-bit frame of 8'h3C with correct odd parity into rx -> one rx_valid, rx_data=8'h3C, both error flags 0.
- Same frame with the parity bit flipped -> rx_parity_err=1. Stop bit low -> rx_frame_err=1. Then a 40-cycle low glitch on idle rx -> no rx_valid.
- Reset asserted mid-TX (bit 4) and mid-RX -> next cycle tx=1, tx_ready=1, rx_busy=0, no stray rx_valid or tx_done.
- DATA_BITS=7, PARITY_MODE=2, STOP_BITS=2 with UART_LOOPBACK_EN and loopback=1: send 7'h55 -> rx_data=7'h55, rx_parity_err=0, tx_done 1 + 11*104 cycles after accept.
